uart_rx_core: RTL

Parametrised UART receiver, the successor to the fixed 8N1 receive controller. It combines the datapath and the FSM in one block and supports 5–9 data bits, optional parity and 1 or 2 stop bits. Bit timing comes from an external oversampling tick, and each bit is resolved by a 3-sample majority vote. Received words leave through a valid/ready handshake, with framing, parity and overrun errors reported alongside; the block sits between the baud generator and the receive FIFO.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_bit_sampler.sv | 58 +++++
 rtl/uart_rx_core.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    RX_IDLE     = 3'd0,
    RX_START    = 3'd1,
    RX_DATA     = 3'd2,
    RX_PARITY   = 3'd3,
    RX_STOP     = 3'd4,
    RX_BRK_WAIT = 3'd5
  } rx_state_t;

  function automatic int tick_cnt_width(input int oversample);
    return $clog2(oversample);
  endfunction

  function automatic logic xor_reduce9(input logic [8:0] d);
    return ^d;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line front end: synchroniser, falling-edge detect and 3-sample mid-bit vote.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int CW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          baud_tick,
  input  logic [CW-1:0] tick_cnt,
  input  logic          serial_in,
  output logic          sync_line,
  output logic          fall_edge,
  output logic          voted_bit
);

  localparam int M = OVERSAMPLE / 2;
  localparam logic [CW-1:0] TICK_A = CW'(M - 1);
  localparam logic [CW-1:0] TICK_B = CW'(M);

  logic [1:0] sync_r;
  logic [1:0] fill_r;
  logic       prev_r;
  logic [1:0] smp_r;

  // Synchroniser; prev_r stays low until sync_r[1] carries a real line sample,
  // so a line already low when reset releases never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b11;
      fill_r <= 2'b00;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], serial_in};
      fill_r <= {fill_r[0], 1'b1};
      prev_r <= sync_r[1] & fill_r[1];
    end
  end

  // Hold the first two mid-bit samples; the third is the live line at tick M+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_r <= 2'b11;
    end else if (baud_tick && (tick_cnt == TICK_A)) begin
      smp_r <= {smp_r[1], sync_r[1]};
    end else if (baud_tick && (tick_cnt == TICK_B)) begin
      smp_r <= {sync_r[1], smp_r[0]};
    end else begin
      smp_r <= smp_r;
    end
  end

  assign sync_line = sync_r[1];
  assign fall_edge = prev_r & ~sync_r[1];
  assign voted_bit = majority3(smp_r[0], smp_r[1], sync_r[1]);

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: frame FSM, tick/bit counters, shift register
// and a valid/ready output word with framing, parity and overrun status.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = tick_cnt_width(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [CW-1:0] TICK_ZERO = CW'(0);
  localparam logic [CW-1:0] TICK_ONE  = CW'(1);
  localparam logic [CW-1:0] TICK_VOTE = CW'(M + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic HAS_PARITY = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
  localparam logic ODD_MODE   = (PARITY == PAR_ODD);

  rx_state_t            state_r, state_n;
  logic [CW-1:0]        tick_r, tick_n, tick_step_s;
  logic [3:0]           bit_r, bit_n;
  logic [DATA_BITS-1:0] shift_r, shift_n;
  logic                 fe_r, fe_n;
  logic                 pe_r, pe_n;
  logic                 at_vote_s, at_last_s;
  logic                 done_s, done_fe_s, load_s;
  logic                 sync_line_s, fall_edge_s, voted_bit_s;

  uart_bit_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .CW         (CW)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .tick_cnt  (tick_r),
    .serial_in (serial_in),
    .sync_line (sync_line_s),
    .fall_edge (fall_edge_s),
    .voted_bit (voted_bit_s)
  );

  // Next-state, counter and accumulator decode
  always_comb begin
    at_vote_s   = baud_tick && (tick_r == TICK_VOTE);
    at_last_s   = baud_tick && (tick_r == TICK_LAST);
    tick_step_s = (tick_r == TICK_LAST) ? TICK_ZERO : (tick_r + TICK_ONE);
    state_n     = state_r;
    tick_n      = baud_tick ? tick_step_s : tick_r;
    bit_n       = bit_r;
    shift_n     = shift_r;
    fe_n        = fe_r;
    pe_n        = pe_r;
    done_s      = 1'b0;
    done_fe_s   = fe_r;
    case (state_r)
      RX_IDLE: begin
        tick_n = TICK_ZERO;
        if (fall_edge_s) begin
          state_n = RX_START;
          bit_n   = 4'd0;
          fe_n    = 1'b0;
          pe_n    = 1'b0;
        end else begin
          state_n = RX_IDLE;
        end
      end
      RX_START: begin
        if (at_vote_s && voted_bit_s) begin
          state_n = RX_IDLE;
          tick_n  = TICK_ZERO;
        end else if (at_last_s) begin
          state_n = RX_DATA;
          bit_n   = 4'd0;
        end else begin
          state_n = RX_START;
        end
      end
      RX_DATA: begin
        if (at_vote_s) begin
          shift_n = {voted_bit_s, shift_r[DATA_BITS-1:1]};
        end else begin
          shift_n = shift_r;
        end
        if (at_last_s && (bit_r == LAST_DATA)) begin
          state_n = HAS_PARITY ? RX_PARITY : RX_STOP;
          bit_n   = 4'd0;
        end else if (at_last_s) begin
          bit_n = bit_r + 4'd1;
        end else begin
          bit_n = bit_r;
        end
      end
      RX_PARITY: begin
        // Error whenever data ones plus the parity bit miss the expected sense
        if (at_vote_s) begin
          pe_n = xor_reduce9(9'(shift_r)) ^ voted_bit_s ^ ODD_MODE;
        end else begin
          pe_n = pe_r;
        end
        if (at_last_s) begin
          state_n = RX_STOP;
          bit_n   = 4'd0;
        end else begin
          state_n = RX_PARITY;
        end
      end
      RX_STOP: begin
        if (at_vote_s && (bit_r == LAST_STOP)) begin
          done_s    = 1'b1;
          done_fe_s = fe_r | ~voted_bit_s;
          tick_n    = TICK_ZERO;
          if (done_fe_s && !sync_line_s) begin
            state_n = RX_BRK_WAIT;
          end else begin
            state_n = RX_IDLE;
          end
        end else if (at_vote_s) begin
          fe_n = fe_r | ~voted_bit_s;
        end else if (at_last_s) begin
          bit_n = bit_r + 4'd1;
        end else begin
          bit_n = bit_r;
        end
      end
      RX_BRK_WAIT: begin
        tick_n = TICK_ZERO;
        if (sync_line_s) begin
          state_n = RX_IDLE;
        end else begin
          state_n = RX_BRK_WAIT;
        end
      end
      default: begin
        state_n = RX_IDLE;
        tick_n  = TICK_ZERO;
      end
    endcase
    load_s = done_s && (!rx_valid || rx_ready);
  end

  // FSM state, counters and per-frame accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RX_IDLE;
      tick_r  <= TICK_ZERO;
      bit_r   <= 4'd0;
      shift_r <= {DATA_BITS{1'b0}};
      fe_r    <= 1'b0;
      pe_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      tick_r  <= tick_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
      fe_r    <= fe_n;
      pe_r    <= pe_n;
    end
  end

  // Output word register, handshake and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= {DATA_BITS{1'b0}};
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy    <= (state_n != RX_IDLE);
      overrun <= done_s && !load_s;
      if (load_s) begin
        rx_data    <= shift_r;
        frame_err  <= done_fe_s;
        parity_err <= pe_r;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

endmodule
